// File: rtl/scp_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
package scp_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int BYTES_PER_WORD = 4;

  // A word access must have its two byte-offset bits clear.
  function automatic logic is_misaligned(input logic [1:0] i_addr_lsb);
    return i_addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage, DEPTH_WORDS x 32, with per-byte write enables.
// Latency: write lands on the clock edge; read data appears one edge after i_re.
// Backpressure: none; read data holds until the next i_re.
module dmem_array
  import scp_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_we,
  input  logic [AW-1:0]             i_waddr,
  input  logic [BYTES_PER_WORD-1:0] i_be,
  input  logic [31:0]               i_wdata,
  input  logic                      i_re,
  input  logic [AW-1:0]             i_raddr,
  output logic [31:0]               o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Byte-masked write and registered read; storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (i_be[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Load/store target: latches one request, waits WAIT_CYCLES, commits, then responds.
// Latency: accept to o_rsp_valid is WAIT_CYCLES+1 cycles.
// Backpressure: one access outstanding; o_req_ready low until the response handshake.
module dmem_responder
  import scp_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [3:0]        i_req_be,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]     CNT_INIT  = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);

  dmem_state_t       r_state;
  dmem_state_t       w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic              r_rsp_err;
  logic              r_rsp_load;

  logic              w_accept;
  logic              w_commit;
  logic              w_rsp_done;
  logic              w_c_we;
  logic [ADDR_W-1:0] w_c_addr;
  logic [31:0]       w_c_wdata;
  logic [3:0]        w_c_be;
  logic              w_c_err;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [31:0]       w_ram_rdata;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshake outputs and the accept/commit/done strobes.
  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_commit    = 1'b1;
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Wait counter: loaded only on accept, counts down to zero and stops there.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= CNT_INIT;
    end else if (r_state == WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Request latch; contents are only meaningful between accept and commit.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_we    <= i_req_we;
      r_addr  <= i_req_addr;
      r_wdata <= i_req_wdata;
      r_be    <= i_req_be;
    end
  end

  // With zero wait states the commit happens on the accept edge, so take the
  // live request; otherwise use the latched copy.
  assign w_c_we    = (r_state == IDLE) ? i_req_we    : r_we;
  assign w_c_addr  = (r_state == IDLE) ? i_req_addr  : r_addr;
  assign w_c_wdata = (r_state == IDLE) ? i_req_wdata : r_wdata;
  assign w_c_be    = (r_state == IDLE) ? i_req_be    : r_be;

  assign w_c_err = is_misaligned(w_c_addr[1:0]) | (w_c_addr[ADDR_W-1:2] >= DEPTH_LIM);

  // A reset arriving on the commit edge drops the access entirely.
  assign w_ram_we = w_commit & w_c_we & ~w_c_err & ~i_reset;
  assign w_ram_re = w_commit & ~w_c_we & ~w_c_err & ~i_reset;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_waddr (w_c_addr[AW+1:2]),
    .i_be    (w_c_be),
    .i_wdata (w_c_wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_c_addr[AW+1:2]),
    .o_rdata (w_ram_rdata)
  );

  // Response qualifiers captured at commit; rdata is gated to zero unless a
  // legal load produced it, which also covers reset and stores.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rsp_err  <= 1'b0;
      r_rsp_load <= 1'b0;
    end else if (w_commit) begin
      r_rsp_err  <= w_c_err;
      r_rsp_load <= ~w_c_we & ~w_c_err;
    end else if (w_rsp_done) begin
      r_rsp_err  <= 1'b0;
      r_rsp_load <= 1'b0;
    end
  end

  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = r_rsp_load ? w_ram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a word-array reference model.
// Latency: checks accept-to-response of WAIT_CYCLES+1 on every access.
// Backpressure: exercises held responses, early rsp_ready and blocked requests.
module tb_dmem_responder;

  localparam int DEPTH  = 1024;
  localparam int WAITC  = 2;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  logic [31:0] ref_mem [DEPTH];

  logic [31:0] rd;
  logic        er;
  int          lat;
  bit          to;
  bit          st;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAITC),
    .ADDR_W      (ADDR_W)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_be    (req_be),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err)
  );

  // ---------------- reference model ----------------
  function automatic bit model_err(input logic [31:0] a);
    return ((a % 4) != 0) || ((a / 4) >= DEPTH);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a);
    if (model_err(a)) return 32'h0;
    return ref_mem[a / 4];
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    if (model_err(a)) return;
    w = ref_mem[a / 4];
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[a / 4] = w;
  endfunction

  function automatic logic [31:0] rand_addr();
    int k = $urandom_range(0, 9);
    int r = $urandom_range(0, 19);
    int w = (r < 16) ? r : DEPTH - 20 + r;
    if (k == 6) return 32'(w * 4 + $urandom_range(1, 3));
    if (k == 7) return 32'((DEPTH + $urandom_range(0, 200)) * 4);
    if (k == 8) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return 32'(w * 4);
  endfunction

  // Drives one full request/response exchange and reports what it observed.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold, input bit early,
                       output logic [31:0] o_rd, output logic o_er, output int o_lat,
                       output bit o_to, output bit o_st);
    int n;
    o_rd = '0; o_er = 1'b0; o_lat = 0; o_to = 1'b0; o_st = 1'b1;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid = 1'b1;
    rsp_ready = early;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin o_to = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    o_lat = 1;
    while (!rsp_valid && o_lat < 20) begin @(posedge clk); #1; o_lat++; end
    if (!rsp_valid) begin o_to = 1'b1; rsp_ready = 1'b0; return; end
    o_rd = rsp_rdata;
    o_er = rsp_err;
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        req_valid = 1'b1; req_addr = addr ^ 32'h40; req_we = ~we;
        if (req_ready !== 1'b0) o_st = 1'b0;
        @(posedge clk); #1;
        if (rsp_valid !== 1'b1 || rsp_rdata !== o_rd || rsp_err !== o_er) o_st = 1'b0;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: ready=%b valid=%b err=%b rdata=%h want 1 0 0 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_store_load();
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, er, lat, to, st);
    model_store(32'h10, 32'hDEADBEEF, 4'hF);
    checks++;
    if (to || lat != WAITC + 1) begin failures++; $display("FAIL store_latency: got %0d (timeout=%0b) want %0d", lat, to, WAITC + 1); end
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL store_rsp: rdata=%h err=%b want 0 0", rd, er); end
    issue(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er, lat, to, st);
    checks++;
    if (to || lat != WAITC + 1) begin failures++; $display("FAIL load_latency: got %0d (timeout=%0b) want %0d", lat, to, WAITC + 1); end
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL load_data: rdata=%h err=%b want deadbeef 0", rd, er); end
  endtask

  task automatic test_byte_enable();
    issue(1'b1, 32'h10, 32'h000000AA, 4'b0001, 0, 1'b0, rd, er, lat, to, st);
    model_store(32'h10, 32'h000000AA, 4'b0001);
    issue(1'b0, 32'h10, 32'h0, 4'b0010, 0, 1'b0, rd, er, lat, to, st);
    checks++;
    if (to || rd !== 32'hDEADBEAA || er !== 1'b0) begin failures++; $display("FAIL byte_enable: rdata=%h err=%b want deadbeaa 0", rd, er); end
  endtask

  task automatic test_errors();
    issue(1'b0, 32'h13, 32'h0, 4'hF, 0, 1'b0, rd, er, lat, to, st);
    checks++;
    if (to || rd !== 32'h0 || er !== 1'b1) begin failures++; $display("FAIL load_misaligned: rdata=%h err=%b want 0 1", rd, er); end
    issue(1'b0, 32'(4 * DEPTH), 32'h0, 4'hF, 0, 1'b0, rd, er, lat, to, st);
    checks++;
    if (to || rd !== 32'h0 || er !== 1'b1) begin failures++; $display("FAIL load_out_of_range: rdata=%h err=%b want 0 1", rd, er); end
    issue(1'b1, 32'h13, 32'h12345678, 4'hF, 0, 1'b0, rd, er, lat, to, st);
    checks++;
    if (to || er !== 1'b1) begin failures++; $display("FAIL store_misaligned_err: err=%b want 1", er); end
    issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 1'b0, rd, er, lat, to, st);
    checks++;
    if (to || er !== 1'b0) begin failures++; $display("FAIL store_be0_err: err=%b want 0", er); end
    issue(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er, lat, to, st);
    checks++;
    if (to || rd !== 32'hDEADBEAA) begin failures++; $display("FAIL word4_unchanged: rdata=%h want deadbeaa", rd); end
    issue(1'b1, 32'(4 * (DEPTH - 1)), 32'h0BADF00D, 4'hF, 0, 1'b0, rd, er, lat, to, st);
    model_store(32'(4 * (DEPTH - 1)), 32'h0BADF00D, 4'hF);
    issue(1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, 0, 1'b0, rd, er, lat, to, st);
    checks++;
    if (to || rd !== 32'h0BADF00D || er !== 1'b0) begin failures++; $display("FAIL last_word: rdata=%h err=%b want 0badf00d 0", rd, er); end
  endtask

  task automatic test_hold();
    issue(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b0, rd, er, lat, to, st);
    checks++;
    if (to || st !== 1'b1 || rd !== model_load(32'h10)) begin
      failures++; $display("FAIL hold_stable: stable=%0b rdata=%h want 1 %h", st, rd, model_load(32'h10));
    end
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL hold_release_idle: ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
    issue(1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, 0, 1'b1, rd, er, lat, to, st);
    checks++;
    if (to || lat != WAITC + 1 || rd !== 32'h0BADF00D) begin
      failures++; $display("FAIL early_ready: lat=%0d rdata=%h want %0d 0badf00d", lat, rd, WAITC + 1);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen;
    issue(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0, rd, er, lat, to, st);
    model_store(32'h20, 32'h11223344, 4'hF);
    // Reset one cycle after accepting a store: the store must vanish.
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF; req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_accept_ready: ready=%b want 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL mid_reset_no_rsp: response seen=1 want 0"); end
    issue(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, er, lat, to, st);
    checks++;
    if (to || rd !== 32'h11223344) begin failures++; $display("FAIL mid_reset_no_write: rdata=%h want 11223344", rd); end
    // Reset while a response is held: the response is discarded.
    req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'h55AA55AA; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    model_store(32'h24, 32'h55AA55AA, 4'hF);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (n >= 20 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL resp_reset: waited=%0d valid=%b err=%b rdata=%h ready=%b want valid 0 ready 1",
                           n, rsp_valid, rsp_err, rsp_rdata, req_ready);
    end
    issue(1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0, rd, er, lat, to, st);
    checks++;
    if (to || rd !== 32'h55AA55AA) begin failures++; $display("FAIL resp_reset_store_kept: rdata=%h want 55aa55aa", rd); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, exp_rd;
    logic [3:0]  be;
    logic        we, exp_er;
    int          hold;
    bit          early;
    // Give every word in the random pool a known value first.
    for (int r = 0; r < 20; r++) begin
      a = 32'(((r < 16) ? r : DEPTH - 20 + r) * 4);
      d = $urandom;
      issue(1'b1, a, d, 4'hF, 0, 1'b0, rd, er, lat, to, st);
      model_store(a, d, 4'hF);
    end
    for (int i = 0; i < 150; i++) begin
      a = rand_addr();
      d = $urandom;
      be = 4'($urandom_range(0, 15));
      we = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      early = ($urandom_range(0, 3) == 0);
      exp_er = model_err(a);
      exp_rd = we ? 32'h0 : model_load(a);
      issue(we, a, d, be, hold, early, rd, er, lat, to, st);
      if (we) model_store(a, d, be);
      checks++;
      if (to || lat != WAITC + 1 || st !== 1'b1) begin
        failures++; $display("FAIL rand_timing[%0d]: lat=%0d timeout=%0b stable=%0b want %0d 0 1", i, lat, to, st, WAITC + 1);
      end
      checks++;
      if (rd !== exp_rd || er !== exp_er) begin
        failures++; $display("FAIL rand_rsp[%0d]: we=%b addr=%h rdata=%h err=%b want %h %b", i, we, a, rd, er, exp_rd, exp_er);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
